// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and
// the baud divider calculation used by both the rx and tx sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int DATA_BITS = 8;

  // clk cycles per oversample tick, rounded down
  function automatic int uart_div(
    input int clk_freq,
    input int baud,
    input int oversample
  );
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clk cycles.
// Ports: clk, reset (async active-low), tick (out).
module uart_baud_tick #(
  parameter int DIV = 26
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with a one-entry valid/ready buffer.
// Ports: clk, reset (async active-low), rx, rx_data/rx_valid/rx_ready,
// busy, frame_err and overrun (one-cycle pulses).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_MID = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0] BI_LAST = 3'(DATA_BITS - 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx: DIV must be >= 1");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  logic tick;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic [1:0] sff;
  logic       rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sff <= 2'b11;
    end else begin
      sff <= {sff[0], rx};
    end
  end

  assign rxs = sff[1];

  uart_rx_state_t state, state_n;
  logic [SCW-1:0] sc, sc_n;
  logic [2:0]     bi, bi_n;
  logic [7:0]     sh, sh_n;
  logic           done;
  logic           bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sc    <= '0;
      bi    <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
      bi    <= bi_n;
      sh    <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    sc_n    = sc;
    bi_n    = bi;
    sh_n    = sh;
    done    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          sc_n    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sc == SC_MID) begin
            sc_n    = '0;
            bi_n    = '0;
            state_n = rxs ? IDLE : DATA;
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc == SC_END) begin
            sc_n = '0;
            sh_n = {rxs, sh[7:1]};
            bi_n = bi + 1'b1;
            if (bi == BI_LAST) begin
              state_n = STOP;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sc == SC_END) begin
            sc_n = '0;
            // leave straight to IDLE so a back-to-back start edge is seen
            if (rxs) begin
              done    = 1'b1;
              state_n = IDLE;
            end else begin
              bad     = 1'b1;
              state_n = BREAK;
            end
          end else begin
            sc_n = sc + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad;
      overrun   <= done && rx_valid && !rx_ready;
      // a draining buffer can take the new byte in the same cycle
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at CLK_FREQ=1.6MHz, BAUD=10k (DIV=10, 160 clk/bit).
// Drives serial frames and checks received bytes, flags and handshake.
module tb_uart_rx;

  localparam int DIV = 10;
  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] got[$];
  int n_fe = 0;
  int n_ov = 0;
  int n_rise = 0;
  int last_rise = 0;
  logic pv = 1'b0;
  int lat = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (rx_valid && !pv) begin
        n_rise++;
        last_rise = cyc;
      end
      pv = rx_valid;
    end else begin
      pv = 1'b0;
    end
  end

  task automatic cw(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    got.delete();
    n_fe = 0;
    n_ov = 0;
    n_rise = 0;
  endtask

  // start every frame on the same divider phase so latency repeats
  task automatic align();
    while (cyc % DIV != 0) cw(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int stop_clk, output int s);
    s = cyc;
    rx = 1'b0;
    cw(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cw(BIT);
    end
    rx = stop;
    cw(stop_clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cw(3);
    nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL rst_data got %h want 00", rx_data); end
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", rx_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL rst_ovr got %b want 0", overrun); end
    reset = 1'b1;
    cw(5);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int s;
    clr();
    rx_ready = 1'b1;
    align();
    send_frame(8'hA5, 1'b1, BIT, s);
    cw(20);
    lat = last_rise - s;
    nvec++; if (n_rise != 1) begin nerr++; $display("FAIL single_pulses got %0d want 1", n_rise); end
    nvec++; if (got.size() != 1) begin nerr++; $display("FAIL single_count got %0d want 1", got.size()); end
    else if (got[0] !== 8'hA5) begin nerr++; $display("FAIL single_data got %h want a5", got[0]); end
    nvec++; if (n_fe != 0 || n_ov != 0) begin nerr++; $display("FAIL single_flags got fe=%0d ov=%0d want 0 0", n_fe, n_ov); end
    nvec++; if (lat < 1400 || lat > 1560) begin nerr++; $display("FAIL single_latency got %0d want 1400..1560", lat); end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] b;
    int s;
    clr();
    rx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b, 1'b1, BIT, s);
      cw($urandom_range(0, 300));
    end
    cw(50);
    nvec++; if (got.size() != exp.size()) begin nerr++; $display("FAIL rand_count got %0d want %0d", got.size(), exp.size()); end
    for (int k = 0; k < exp.size() && k < got.size(); k++) begin
      nvec++; if (got[k] !== exp[k]) begin nerr++; $display("FAIL rand_data[%0d] got %h want %h", k, got[k], exp[k]); end
    end
    nvec++; if (n_fe != 0 || n_ov != 0) begin nerr++; $display("FAIL rand_flags got fe=%0d ov=%0d want 0 0", n_fe, n_ov); end
  endtask

  task automatic test_back_to_back();
    int s;
    clr();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, BIT, s);
    send_frame(8'hC3, 1'b1, BIT, s);
    cw(30);
    nvec++; if (rx_valid !== 1'b1) begin nerr++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
    nvec++; if (rx_data !== 8'h3C) begin nerr++; $display("FAIL b2b_hold got %h want 3c", rx_data); end
    nvec++; if (n_ov != 1) begin nerr++; $display("FAIL b2b_overrun got %0d want 1", n_ov); end
    rx_ready = 1'b1;
    cw(1);
    rx_ready = 1'b0;
    cw(1);
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL b2b_drop got %b want 0", rx_valid); end
    nvec++; if (got.size() != 1 || got[0] !== 8'h3C) begin nerr++; $display("FAIL b2b_accept got n=%0d want 1 byte 3c", got.size()); end
  endtask

  task automatic test_glitch();
    clr();
    rx = 1'b0;
    cw(20);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL glitch_busy got %b want 1", busy); end
    cw(20);
    rx = 1'b1;
    cw(200);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL glitch_idle got %b want 0", busy); end
    nvec++; if (n_rise != 0 || n_fe != 0 || n_ov != 0) begin nerr++; $display("FAIL glitch_quiet got v=%0d fe=%0d ov=%0d want 0 0 0", n_rise, n_fe, n_ov); end
  endtask

  task automatic test_frame_err();
    int s;
    clr();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 2 * BIT, s);
    nvec++; if (n_fe != 1) begin nerr++; $display("FAIL ferr_pulse got %0d want 1", n_fe); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL ferr_break got %b want 1", busy); end
    rx = 1'b1;
    cw(20);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ferr_idle got %b want 0", busy); end
    nvec++; if (n_rise != 0) begin nerr++; $display("FAIL ferr_novalid got %0d want 0", n_rise); end
    send_frame(8'h12, 1'b1, BIT, s);
    cw(20);
    nvec++; if (got.size() != 1 || got[0] !== 8'h12) begin nerr++; $display("FAIL ferr_next got n=%0d want 1 byte 12", got.size()); end
    nvec++; if (n_fe != 1) begin nerr++; $display("FAIL ferr_once got %0d want 1", n_fe); end
  endtask

  task automatic test_commit_drain();
    int s;
    int tgt;
    logic [7:0] b;
    clr();
    rx_ready = 1'b0;
    align();
    send_frame(8'h01, 1'b1, BIT, s);
    cw(20);
    nvec++; if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin nerr++; $display("FAIL cd_first got v=%b d=%h want 1 01", rx_valid, rx_data); end
    align();
    s = cyc;
    b = 8'h02;
    rx = 1'b0;
    cw(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cw(BIT);
    end
    rx = 1'b1;
    tgt = s + lat - 1;
    while (cyc < tgt) cw(1);
    rx_ready = 1'b1;
    cw(1);
    rx_ready = 1'b0;
    cw(BIT);
    nvec++; if (rx_valid !== 1'b1) begin nerr++; $display("FAIL cd_valid got %b want 1", rx_valid); end
    nvec++; if (rx_data !== 8'h02) begin nerr++; $display("FAIL cd_data got %h want 02", rx_data); end
    nvec++; if (n_ov != 0) begin nerr++; $display("FAIL cd_overrun got %0d want 0", n_ov); end
    nvec++; if (got.size() != 1 || got[0] !== 8'h01) begin nerr++; $display("FAIL cd_drain got n=%0d want 1 byte 01", got.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    clr();
    rx = 1'b0;
    cw(BIT);
    rx = 1'b1;
    cw(4 * BIT + BIT / 2);
    reset = 1'b0;
    #1;
    nvec++; if (rx_data !== 8'h00) begin nerr++; $display("FAIL rmid_data got %h want 00", rx_data); end
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b want 0", rx_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
    nvec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin nerr++; $display("FAIL rmid_flags got %b%b want 00", frame_err, overrun); end
    cw(5);
    reset = 1'b1;
    cw(BIT * 6);
    nvec++; if (n_fe != 0 || n_ov != 0 || n_rise != 0) begin nerr++; $display("FAIL rmid_quiet got fe=%0d ov=%0d v=%0d want 0 0 0", n_fe, n_ov, n_rise); end
    rx_ready = 1'b1;
    send_frame(8'h80, 1'b1, BIT, s);
    cw(20);
    nvec++; if (got.size() != 1 || got[0] !== 8'h80) begin nerr++; $display("FAIL rmid_next got n=%0d want 1 byte 80", got.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_commit_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
